led_ctrl: RTL and testbench

Parametrised multi-channel status-LED controller for the SoC top level. It replaces the single hard-wired power-on/activity counter with CHANNELS independent channels, each with a per-channel mode: off, on, blink, or activity pulse-stretch. Event inputs are synchronised internally, so asynchronous status signals such as sleep or USB activity connect directly. It runs in one clock domain, typically the 1 MHz prescaler output.

---
 rtl/led_ctrl.sv | 68 ++++++
 tb/tb_led_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
// Multi-channel status-LED controller: per-channel off/on/blink/activity modes,
// with a shared blink counter and a per-channel synchronised pulse stretcher.
module led_ctrl #(
    parameter int unsigned              CHANNELS    = 2,
    parameter int unsigned              CNT_WIDTH   = 21,
    parameter logic [CNT_WIDTH-1:0]     RELOAD      = {1'b0, 3'b111, {(CNT_WIDTH-4){1'b0}}},
    parameter int unsigned              SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0]      INVERT      = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [2*CHANNELS-1:0]   mode_i,
    input  logic [CHANNELS-1:0]     event_i,
    output logic [CHANNELS-1:0]     led_o,
    output logic                    tick_o
);

    localparam int unsigned MSB = CNT_WIDTH - 1;

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] blink_q;
    logic [CHANNELS-1:0]  ev_s;
    logic [CHANNELS-1:0]  lv_c;

    assign ev_s = sync_q[SYNC_STAGES-1];

    // Logical LED value per channel, selected by its mode field.
    always_comb begin
        lv_c = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            case (mode_i[2*c +: 2])
                2'b00:   lv_c[c] = 1'b0;
                2'b01:   lv_c[c] = 1'b1;
                2'b10:   lv_c[c] = blink_q[MSB];
                default: lv_c[c] = ~cnt_q[c][MSB];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) cnt_q[c] <= '0;
            blink_q <= '0;
            tick_o  <= 1'b0;
            led_o   <= INVERT;
        end else begin
            sync_q[0] <= event_i;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];

            blink_q <= blink_q + CNT_WIDTH'(1);
            tick_o  <= &blink_q;

            // Stretch counter: count up to MSB, then saturate until an event reloads it.
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (!cnt_q[c][MSB]) begin
                    cnt_q[c] <= cnt_q[c] + CNT_WIDTH'(1);
                end else if (ev_s[c]) begin
                    cnt_q[c] <= RELOAD;
                end
            end

            led_o <= lv_c ^ INVERT;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Randomised bench for led_ctrl; expectations come from an edge-count model of
// pulse windows and blink phases.
module tb_led_ctrl;

    localparam int unsigned CH     = 2;
    localparam int unsigned W      = 6;
    localparam int unsigned SYNC   = 2;
    localparam logic [W-1:0] RLD   = 6'd28;
    localparam logic [CH-1:0] INV  = 2'b10;
    localparam int HALF   = 32;
    localparam int PERIOD = 64;
    localparam int PULSE  = HALF - 28;

    logic          clk_i   = 1'b0;
    logic          rstn_i  = 1'b0;
    logic [3:0]    mode_i  = 4'b1111;
    logic [CH-1:0] event_i = '0;
    logic [CH-1:0] led_o;
    logic          tick_o;

    int checks = 0;
    int errors = 0;

    // Model state: g = absolute edge count, n = edges since last reset edge,
    // au[c] = last edge on which channel c's activity window is lit.
    int g = 0;
    int n = 0;
    int au [CH];
    logic [CH-1:0] ev_at [8192];
    logic [3:0] cur_mode = 4'b1111;

    led_ctrl #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (W),
        .RELOAD      (RLD),
        .SYNC_STAGES (SYNC),
        .INVERT      (INV)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .mode_i  (mode_i),
        .event_i (event_i),
        .led_o   (led_o),
        .tick_o  (tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d n=%0d got=%h exp=%h", tag, g, n, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic r, input logic [3:0] m, input logic [CH-1:0] e);
        logic [CH-1:0] ev_eff;
        logic [CH-1:0] exp_led;
        logic          exp_tick;
        logic          lv;
        bit            lit;
        @(negedge clk_i);
        rstn_i  = r;
        mode_i  = m;
        event_i = e;
        @(posedge clk_i);
        ev_eff   = (g >= 2) ? ev_at[g-2] : '0;
        ev_at[g] = r ? e : '0;
        g++;
        exp_led  = INV;
        exp_tick = 1'b0;
        if (!r) begin
            n = 0;
            for (int c = 0; c < int'(CH); c++) au[c] = HALF;
        end else begin
            n++;
            exp_tick = (((n - 1) % PERIOD) == PERIOD - 1);
            for (int c = 0; c < int'(CH); c++) begin
                lit = (n <= au[c]);
                case (m[2*c +: 2])
                    2'b00:   lv = 1'b0;
                    2'b01:   lv = 1'b1;
                    2'b10:   lv = (((n - 1) % PERIOD) >= HALF);
                    default: lv = lit;
                endcase
                if (!lit && ev_eff[c]) au[c] = n + PULSE;
                exp_led[c] = lv ^ INV[c];
            end
        end
        #1;
        check("led", 8'(led_o), 8'(exp_led));
        check("tick", 8'(tick_o), 8'(exp_tick));
    endtask

    task automatic idle(input int cycles, input logic [CH-1:0] e);
        for (int i = 0; i < cycles; i++) cycle(1'b1, cur_mode, e);
    endtask

    initial begin
        for (int c = 0; c < int'(CH); c++) au[c] = HALF;

        // Reset and power-on indication in activity mode.
        cur_mode = 4'b1111;
        for (int i = 0; i < 3; i++) cycle(1'b0, cur_mode, '0);
        idle(40, '0);

        // Single-cycle activity pulses with random spacing; channel 1 random.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, cur_mode, {1'($urandom_range(0, 1)), 1'b1});
            idle(int'($urandom_range(2, 12)), '0);
        end

        // Continuous request on channel 0.
        for (int i = 0; i < 30; i++) cycle(1'b1, cur_mode, {1'($urandom_range(0, 1)), 1'b1});
        idle(10, '0);

        // Blink on channel 0 across several periods.
        cur_mode = 4'b1110;
        for (int i = 0; i < 140; i++) cycle(1'b1, cur_mode, CH'($urandom));

        // Step channel 1 through every mode.
        for (int md = 0; md < 4; md++) begin
            cur_mode = {2'(md), 2'b10};
            idle(6, CH'($urandom));
        end

        // Reset in the middle of an activity pulse.
        cur_mode = 4'b1111;
        idle(40, '0);
        cycle(1'b1, cur_mode, 2'b11);
        idle(5, '0);
        cycle(1'b0, cur_mode, '0);
        idle(40, '0);

        // Random mix of modes, events and occasional resets.
        for (int i = 0; i < 1800; i++) begin
            logic r;
            logic [CH-1:0] e;
            if ($urandom_range(0, 15) == 0) cur_mode = 4'($urandom);
            r = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < int'(CH); c++) e[c] = ($urandom_range(0, 3) == 0);
            cycle(r, cur_mode, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout edge=%0d", g);
        $fatal(1);
    end

endmodule
